// File: rtl/regfile_scoreboard.sv
// Integer register file: NRD combinational read ports, one writeback port with optional
// write-to-read bypass, and a per-register busy scoreboard (issue sets, writeback clears).
module regfile_scoreboard #(
    parameter int  XLEN     = 32,
    parameter int  NREGS    = 32,
    parameter int  NRD      = 2,
    parameter int  BYPASS   = 1,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_rd,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_d;
    logic             wb_write_s;
    logic [NREGS-1:0] wb_clr_s;
    logic [NREGS-1:0] issue_set_s;
    logic [AW-1:0]    rd_addr_s;

    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] vec);
        logic [AW:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + {{AW{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Next register contents and busy vector; flush beats issue, issue beats wb-clear.
    always_comb begin
        wb_write_s  = wb_en && !is_zero_reg(wb_addr);
        wb_clr_s    = wb_en ? ({{(NREGS-1){1'b0}}, 1'b1} << wb_addr) : '0;
        issue_set_s = (issue_en && !is_zero_reg(issue_rd))
                      ? ({{(NREGS-1){1'b0}}, 1'b1} << issue_rd) : '0;
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = (wb_write_s && (wb_addr == AW'(i))) ? wb_data : regs_q[i];
        end
        busy_d     = flush ? '0 : ((busy_q & ~wb_clr_s) | issue_set_s);
        busy_cnt_d = popcount(busy_d);
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Combinational read ports; a writeback in flight during reset is not forwarded.
    always_comb begin
        rs_data   = '0;
        rs_busy   = '0;
        rd_addr_s = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_addr_s = rs_addr[i*AW +: AW];
            if (is_zero_reg(rd_addr_s)) begin
                rs_data[i*XLEN +: XLEN] = '0;
                rs_busy[i]              = 1'b0;
            end else if ((BYPASS != 0) && wb_en && !reset && (wb_addr == rd_addr_s)) begin
                rs_data[i*XLEN +: XLEN] = wb_data;
                rs_busy[i]              = 1'b0;
            end else begin
                rs_data[i*XLEN +: XLEN] = regs_q[rd_addr_s];
                rs_busy[i]              = busy_q[rd_addr_s];
            end
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: instance A (defaults) and instance B (XLEN=64, NREGS=16,
// NRD=3, BYPASS=0, ZERO_REG=0) share stimulus and are checked against array models.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        issue_en, wb_en, flush;
    logic [4:0]  issue_rd, wb_addr;
    logic [63:0] wb_data;
    logic [4:0]  raddr [3];

    logic [9:0]   a_rs_addr;
    logic [63:0]  a_rs_data;
    logic [1:0]   a_rs_busy;
    logic [5:0]   a_busy_cnt;
    logic [11:0]  b_rs_addr;
    logic [191:0] b_rs_data;
    logic [2:0]   b_rs_busy;
    logic [4:0]   b_busy_cnt;

    assign a_rs_addr = {raddr[1], raddr[0]};
    assign b_rs_addr = {raddr[2][3:0], raddr[1][3:0], raddr[0][3:0]};

    regfile_scoreboard u_a (
        .clk(clk), .reset(reset), .rs_addr(a_rs_addr), .rs_data(a_rs_data),
        .rs_busy(a_rs_busy), .issue_en(issue_en), .issue_rd(issue_rd), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data[31:0]), .flush(flush), .busy_cnt(a_busy_cnt)
    );

    regfile_scoreboard #(.XLEN(64), .NREGS(16), .NRD(3), .BYPASS(0), .ZERO_REG(0)) u_b (
        .clk(clk), .reset(reset), .rs_addr(b_rs_addr), .rs_data(b_rs_data),
        .rs_busy(b_rs_busy), .issue_en(issue_en), .issue_rd(issue_rd[3:0]), .wb_en(wb_en),
        .wb_addr(wb_addr[3:0]), .wb_data(wb_data), .flush(flush), .busy_cnt(b_busy_cnt)
    );

    // Architectural models of both instances.
    logic [31:0] ma_reg [32];
    bit          ma_busy [32];
    logic [63:0] mb_reg [16];
    bit          mb_busy [16];
    int total = 0;
    int bad = 0;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin ma_reg[i] = '0; ma_busy[i] = 1'b0; end
        for (int i = 0; i < 16; i++) begin mb_reg[i] = '0; mb_busy[i] = 1'b0; end
    endtask

    function automatic int ma_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(ma_busy[i]);
        return n;
    endfunction

    function automatic int mb_count();
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(mb_busy[i]);
        return n;
    endfunction

    task automatic idle();
        issue_en = 1'b0; issue_rd = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) raddr[i] = '0;
    endtask

    // Apply the architectural effect of the current inputs, then advance one clock.
    task automatic tick();
        if (wb_en) begin
            if (wb_addr != 5'd0) ma_reg[wb_addr] = wb_data[31:0];
            ma_busy[wb_addr] = 1'b0;
            mb_reg[wb_addr[3:0]] = wb_data;
            mb_busy[wb_addr[3:0]] = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < 32; i++) ma_busy[i] = 1'b0;
            for (int i = 0; i < 16; i++) mb_busy[i] = 1'b0;
        end else if (issue_en) begin
            if (issue_rd != 5'd0) ma_busy[issue_rd] = 1'b1;
            mb_busy[issue_rd[3:0]] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (a_busy_cnt !== 6'd0) begin bad++; $display("FAIL por_cnt_a got=%0d want=0", a_busy_cnt); end
        total++; if (b_busy_cnt !== 5'd0) begin bad++; $display("FAIL por_cnt_b got=%0d want=0", b_busy_cnt); end
        reset = 1'b0;
        model_clear();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'h0000_0000_DEAD_BEEF;
        tick();
        idle(); issue_en = 1'b1; issue_rd = 5'd7;
        tick();
        idle(); raddr[0] = 5'd5; raddr[1] = 5'd7;
        #1;
        total++; if (a_rs_data[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL t1_pre_data_a got=%h want=deadbeef", a_rs_data[31:0]); end
        total++; if (a_busy_cnt !== 6'd1) begin bad++; $display("FAIL t1_pre_cnt_a got=%0d want=1", a_busy_cnt); end
        reset = 1'b1;
        #1;
        total++; if (a_rs_data[31:0] !== 32'd0) begin bad++; $display("FAIL t1_data_a got=%h want=0", a_rs_data[31:0]); end
        total++; if (a_rs_busy[1] !== 1'b0) begin bad++; $display("FAIL t1_busy_a got=%b want=0", a_rs_busy[1]); end
        total++; if (a_busy_cnt !== 6'd0) begin bad++; $display("FAIL t1_cnt_a got=%0d want=0", a_busy_cnt); end
        total++; if (b_rs_data[63:0] !== 64'd0) begin bad++; $display("FAIL t1_data_b got=%h want=0", b_rs_data[63:0]); end
        total++; if (b_rs_busy[1] !== 1'b0) begin bad++; $display("FAIL t1_busy_b got=%b want=0", b_rs_busy[1]); end
        total++; if (b_busy_cnt !== 5'd0) begin bad++; $display("FAIL t1_cnt_b got=%0d want=0", b_busy_cnt); end
        model_clear();
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_zero_reg();
        idle();
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 64'h1234_5678;
        issue_en = 1'b1; issue_rd = 5'd0;
        #1;
        total++; if (a_rs_data[31:0] !== 32'd0) begin bad++; $display("FAIL t2_comb_a got=%h want=0", a_rs_data[31:0]); end
        tick();
        idle();
        #1;
        total++; if (a_rs_data[31:0] !== 32'd0) begin bad++; $display("FAIL t2_data_a got=%h want=0", a_rs_data[31:0]); end
        total++; if (a_rs_busy[0] !== 1'b0) begin bad++; $display("FAIL t2_busy_a got=%b want=0", a_rs_busy[0]); end
        total++; if (a_busy_cnt !== 6'd0) begin bad++; $display("FAIL t2_cnt_a got=%0d want=0", a_busy_cnt); end
        total++; if (b_rs_data[63:0] !== 64'h1234_5678) begin bad++; $display("FAIL t2_data_b got=%h want=12345678", b_rs_data[63:0]); end
        total++; if (b_rs_busy[0] !== 1'b1) begin bad++; $display("FAIL t2_busy_b got=%b want=1", b_rs_busy[0]); end
        total++; if (b_busy_cnt !== 5'd1) begin bad++; $display("FAIL t2_cnt_b got=%0d want=1", b_busy_cnt); end
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 64'd0;
        tick();
        idle();
        #1;
        total++; if (b_busy_cnt !== 5'd0) begin bad++; $display("FAIL t2_clr_cnt_b got=%0d want=0", b_busy_cnt); end
    endtask

    task automatic test_bypass();
        idle(); issue_en = 1'b1; issue_rd = 5'd3;
        tick();
        idle();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'hA5A5_A5A5_A5A5_A5A5; raddr[0] = 5'd3;
        #1;
        total++; if (a_rs_data[31:0] !== 32'hA5A5_A5A5) begin bad++; $display("FAIL t3_byp_data_a got=%h want=a5a5a5a5", a_rs_data[31:0]); end
        total++; if (a_rs_busy[0] !== 1'b0) begin bad++; $display("FAIL t3_byp_busy_a got=%b want=0", a_rs_busy[0]); end
        total++; if (b_rs_data[63:0] !== 64'd0) begin bad++; $display("FAIL t3_old_data_b got=%h want=0", b_rs_data[63:0]); end
        total++; if (b_rs_busy[0] !== 1'b1) begin bad++; $display("FAIL t3_old_busy_b got=%b want=1", b_rs_busy[0]); end
        tick();
        idle(); raddr[0] = 5'd3;
        #1;
        total++; if (b_rs_data[63:0] !== 64'hA5A5_A5A5_A5A5_A5A5) begin bad++; $display("FAIL t3_new_data_b got=%h want=a5a5a5a5a5a5a5a5", b_rs_data[63:0]); end
        total++; if (b_busy_cnt !== 5'd0) begin bad++; $display("FAIL t3_cnt_b got=%0d want=0", b_busy_cnt); end
        total++; if (a_busy_cnt !== 6'd0) begin bad++; $display("FAIL t3_cnt_a got=%0d want=0", a_busy_cnt); end
    endtask

    task automatic test_scoreboard();
        idle(); issue_en = 1'b1; issue_rd = 5'd4;
        tick();
        idle(); raddr[1] = 5'd4;
        #1;
        total++; if (a_rs_busy[1] !== 1'b1) begin bad++; $display("FAIL t4_busy_a got=%b want=1", a_rs_busy[1]); end
        total++; if (a_busy_cnt !== 6'd1) begin bad++; $display("FAIL t4_cnt_a got=%0d want=1", a_busy_cnt); end
        total++; if (b_rs_busy[1] !== 1'b1) begin bad++; $display("FAIL t4_busy_b got=%b want=1", b_rs_busy[1]); end
        total++; if (b_busy_cnt !== 5'd1) begin bad++; $display("FAIL t4_cnt_b got=%0d want=1", b_busy_cnt); end
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 64'd7;
        tick();
        idle(); raddr[1] = 5'd4;
        #1;
        total++; if (a_rs_data[63:32] !== 32'd7) begin bad++; $display("FAIL t4_data_a got=%h want=7", a_rs_data[63:32]); end
        total++; if (a_rs_busy[1] !== 1'b0) begin bad++; $display("FAIL t4_clr_a got=%b want=0", a_rs_busy[1]); end
        total++; if (a_busy_cnt !== 6'd0) begin bad++; $display("FAIL t4_cnt0_a got=%0d want=0", a_busy_cnt); end
        total++; if (b_rs_data[127:64] !== 64'd7) begin bad++; $display("FAIL t4_data_b got=%h want=7", b_rs_data[127:64]); end
        total++; if (b_busy_cnt !== 5'd0) begin bad++; $display("FAIL t4_cnt0_b got=%0d want=0", b_busy_cnt); end
    endtask

    task automatic test_simultaneous();
        idle(); issue_en = 1'b1; issue_rd = 5'd9;
        tick();
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 64'h55;
        tick();
        idle(); raddr[1] = 5'd9;
        #1;
        total++; if (a_rs_data[63:32] !== 32'h55) begin bad++; $display("FAIL t5_data_a got=%h want=55", a_rs_data[63:32]); end
        total++; if (a_rs_busy[1] !== 1'b1) begin bad++; $display("FAIL t5_busy_a got=%b want=1", a_rs_busy[1]); end
        total++; if (a_busy_cnt !== 6'd1) begin bad++; $display("FAIL t5_cnt_a got=%0d want=1", a_busy_cnt); end
        total++; if (b_rs_busy[1] !== 1'b1) begin bad++; $display("FAIL t5_busy_b got=%b want=1", b_rs_busy[1]); end
        total++; if (b_busy_cnt !== 5'd1) begin bad++; $display("FAIL t5_cnt_b got=%0d want=1", b_busy_cnt); end
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 64'h55;
        tick();
        idle();
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 3; r++) begin
            idle(); issue_en = 1'b1; issue_rd = 5'(r);
            tick();
        end
        idle();
        #1;
        total++; if (a_busy_cnt !== 6'd3) begin bad++; $display("FAIL t6_cnt3_a got=%0d want=3", a_busy_cnt); end
        total++; if (b_busy_cnt !== 5'd3) begin bad++; $display("FAIL t6_cnt3_b got=%0d want=3", b_busy_cnt); end
        flush = 1'b1; issue_en = 1'b1; issue_rd = 5'd6;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 64'h11;
        tick();
        idle(); raddr[0] = 5'd1; raddr[1] = 5'd6; raddr[2] = 5'd3;
        #1;
        total++; if (a_busy_cnt !== 6'd0) begin bad++; $display("FAIL t6_cnt_a got=%0d want=0", a_busy_cnt); end
        total++; if (a_rs_data[31:0] !== 32'h11) begin bad++; $display("FAIL t6_data_a got=%h want=11", a_rs_data[31:0]); end
        total++; if (a_rs_busy !== 2'b00) begin bad++; $display("FAIL t6_busy_a got=%b want=00", a_rs_busy); end
        total++; if (b_busy_cnt !== 5'd0) begin bad++; $display("FAIL t6_cnt_b got=%0d want=0", b_busy_cnt); end
        total++; if (b_rs_busy !== 3'b000) begin bad++; $display("FAIL t6_busy_b got=%b want=000", b_rs_busy); end
        total++; if (b_rs_data[63:0] !== 64'h11) begin bad++; $display("FAIL t6_data_b got=%h want=11", b_rs_data[63:0]); end
    endtask

    task automatic test_random();
        logic [31:0] ea_d;
        logic [63:0] eb_d;
        logic        e_b;
        logic [4:0]  a;
        for (int n = 0; n < 400; n++) begin
            issue_en = ($urandom_range(0, 99) < 45);
            issue_rd = 5'($urandom_range(0, 31));
            wb_en    = ($urandom_range(0, 99) < 50);
            wb_addr  = ($urandom_range(0, 3) == 0) ? issue_rd : 5'($urandom_range(0, 31));
            wb_data  = {$urandom, $urandom};
            flush    = ($urandom_range(0, 99) < 5);
            for (int i = 0; i < 3; i++) raddr[i] = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) raddr[0] = wb_addr;
            #1;
            for (int i = 0; i < 2; i++) begin
                a = raddr[i];
                if (a == 5'd0) begin
                    ea_d = '0; e_b = 1'b0;
                end else if (wb_en && wb_addr == a) begin
                    ea_d = wb_data[31:0]; e_b = 1'b0;
                end else begin
                    ea_d = ma_reg[a]; e_b = ma_busy[a];
                end
                total++; if (a_rs_data[i*32 +: 32] !== ea_d) begin bad++; $display("FAIL rnd_data_a n=%0d port=%0d got=%h want=%h", n, i, a_rs_data[i*32 +: 32], ea_d); end
                total++; if (a_rs_busy[i] !== e_b) begin bad++; $display("FAIL rnd_busy_a n=%0d port=%0d got=%b want=%b", n, i, a_rs_busy[i], e_b); end
            end
            for (int i = 0; i < 3; i++) begin
                eb_d = mb_reg[raddr[i][3:0]];
                e_b  = mb_busy[raddr[i][3:0]];
                total++; if (b_rs_data[i*64 +: 64] !== eb_d) begin bad++; $display("FAIL rnd_data_b n=%0d port=%0d got=%h want=%h", n, i, b_rs_data[i*64 +: 64], eb_d); end
                total++; if (b_rs_busy[i] !== e_b) begin bad++; $display("FAIL rnd_busy_b n=%0d port=%0d got=%b want=%b", n, i, b_rs_busy[i], e_b); end
            end
            tick();
            total++; if (a_busy_cnt !== 6'(ma_count())) begin bad++; $display("FAIL rnd_cnt_a n=%0d got=%0d want=%0d", n, a_busy_cnt, ma_count()); end
            total++; if (b_busy_cnt !== 5'(mb_count())) begin bad++; $display("FAIL rnd_cnt_b n=%0d got=%0d want=%0d", n, b_busy_cnt, mb_count()); end
        end
        idle();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
